ifetch: RTL and testbench

Instruction fetch stage of the core. It holds the program counter, issues word fetches to instruction memory under a credit scheme, and buffers returned words in a small FIFO. It presents each instruction, its PC, and a pre-decoded immediate-format select to the decode/sign-extend stage. Branch/jump redirects flush all buffered and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 45 ++++
 rtl/ifetch_fifo.sv | 67 ++++++
 rtl/ifetch.sv | 163 ++++++++++++++++
 tb/tb_ifetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch definitions: word size, immediate-format encodings, opcodes, default reset PC.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef IFETCH_DEFS_SVH
`define IFETCH_DEFS_SVH
`define WORDSIZE 32
`define EXTNR_R 2'b00
`define EXTNR_I 2'b01
`define EXTNR_S 2'b10
`define EXTNR_B 2'b11
`endif

package ifetch_pkg;

    localparam int WORD_W = `WORDSIZE;
    localparam logic [`WORDSIZE-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Immediate-format select encodings
    localparam logic [1:0] IMM_R = `EXTNR_R;
    localparam logic [1:0] IMM_I = `EXTNR_I;
    localparam logic [1:0] IMM_S = `EXTNR_S;
    localparam logic [1:0] IMM_B = `EXTNR_B;

    // Opcodes that carry an I/S/B immediate
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // LUI, AUIPC, JAL, system and register ops all map to the R select
    function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
        logic [1:0] sel;
        case (opcode)
            OP_BRANCH: sel = IMM_B;
            OP_STORE:  sel = IMM_S;
            OP_OPIMM,
            OP_LOAD,
            OP_JALR:   sel = IMM_I;
            default:   sel = IMM_R;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of DEPTH entries (DEPTH a power of two) with synchronous flush.
// Latency: a push at edge N is visible at the head from cycle N+1.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module ifetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full,
    output logic [2:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == 3'd0);
    assign full     = (count == DEPTH_C);
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage write; no reset needed since the head is only trusted when not empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; flush discards everything including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, credit-limited imem requests, PC-tagged response FIFO, imm-format predecode.
// Latency: a response captured at edge N is presented on inst_* from cycle N+1; imm_ops is combinational from the head.
// Backpressure: requests stop when in-flight plus buffered reaches DEPTH; inst_ready low holds the head. IFETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [`WORDSIZE-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                   DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [`WORDSIZE-1:0] imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [`WORDSIZE-1:0] imem_rsp_data,
    input  logic                 redirect_valid,
    input  logic [`WORDSIZE-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [`WORDSIZE-1:0] inst,
    output logic [`WORDSIZE-1:0] inst_pc,
    output logic [1:0]           imm_ops,
    output logic                 fetch_fault
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam int         DW      = 2 * `WORDSIZE;

    logic [`WORDSIZE-1:0] pc;
    logic [`WORDSIZE-1:0] redir_target;
    logic [`WORDSIZE-1:0] pcq_head;
    logic [DW-1:0]        fifo_head;
    logic [2:0]           infl_cnt;
    logic [2:0]           infl_next;
    logic [2:0]           drop_cnt;
    logic [2:0]           occ;
    logic [2:0]           pcq_count;
    logic                 fault_q;
    logic                 req_hs;
    logic                 live_rsp;
    logic                 do_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pcq_empty;
    logic                 pcq_full;

    // Credits: every issued request is guaranteed a FIFO slot, dropped ones included until they return
    assign imem_req_valid = ((infl_cnt + occ) < DEPTH_C) && !fault_q;
    assign imem_addr      = pc;
    assign req_hs         = imem_req_valid & imem_req_ready;

    // A redirect turns any same-cycle response into a dropped one and cancels a same-cycle pop
    assign live_rsp = imem_rsp_valid & (drop_cnt == 3'd0) & ~redirect_valid;
    assign do_pop   = inst_valid & inst_ready & ~redirect_valid;

    assign inst_valid = ~fifo_empty;
    assign inst       = inst_valid ? fifo_head[DW-1 -: `WORDSIZE] : '0;
    assign inst_pc    = inst_valid ? fifo_head[`WORDSIZE-1:0] : '0;
    assign imm_ops    = imm_sel(inst[6:0]);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign redir_target = redirect_pc;

    // Fault is set by a misaligned redirect and cleared by the next aligned one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= |redirect_pc[1:0];
        end
    end
`else
    assign redir_target = redirect_pc & ~32'h3;
    assign fault_q      = 1'b0;
`endif

    assign fetch_fault = fault_q;

    // Outstanding request count after this cycle's handshake and response
    always_comb begin
        infl_next = infl_cnt;
        if (req_hs) begin
            infl_next = infl_next + 3'd1;
        end
        if (imem_rsp_valid) begin
            infl_next = infl_next - 3'd1;
        end
    end

    // PC, in-flight and drop bookkeeping; redirect marks everything still outstanding as stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            infl_cnt <= 3'd0;
            drop_cnt <= 3'd0;
        end else begin
            infl_cnt <= infl_next;
            if (redirect_valid) begin
                pc       <= redir_target;
                drop_cnt <= infl_next;
            end else begin
                if (req_hs) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid && drop_cnt != 3'd0) begin
                    drop_cnt <= drop_cnt - 3'd1;
                end
            end
        end
    end

    // PC of each live outstanding request, popped as its response returns
    ifetch_fifo #(
        .W     (`WORDSIZE),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (req_hs),
        .push_dat (pc),
        .pop      (live_rsp),
        .head_dat (pcq_head),
        .empty    (pcq_empty),
        .full     (pcq_full),
        .count    (pcq_count)
    );

    // Returned instructions paired with their PC, waiting for decode
    ifetch_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_ifq (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (live_rsp),
        .push_dat ({imem_rsp_data, pcq_head}),
        .pop      (do_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (occ)
    );

`ifndef SYNTHESIS
    // Memory must not answer a request that was never made
    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && infl_cnt == 3'd0));
    // Credits guarantee a slot for every live response
    a_rsp_fifo_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(live_rsp && fifo_full && !do_pop));
    a_pcq_under: assert property (@(posedge clk) disable iff (!rst_n)
        !(live_rsp && pcq_empty));
    a_pcq_over: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_hs && !redirect_valid && pcq_full && !live_rsp));
    // Every outstanding request is either tagged or scheduled to be dropped
    a_infl_split: assert property (@(posedge clk) disable iff (!rst_n)
        ((pcq_count + drop_cnt) == infl_cnt));
`endif

endmodule

// File: tb/tb_ifetch.sv
`timescale 1ns/1ps
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  imm_ops;
    logic        fetch_fault;

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .imm_ops        (imm_ops),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding requests tagged with the redirect epoch they belong to
    typedef struct { logic [31:0] addr; int ep; } req_t;
    req_t        mem_q[$];
    logic [31:0] memimg [logic [31:0]];
    int          epoch;
    int          live_buf;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pop;
    bit          fault_m;

    // Stimulus knobs (percent chances) and forced redirect
    int          k_ready, k_rsp, k_pop, k_redir;
    bit          f_redir, f_need_hs, f_need_rsp, f_done;
    logic [31:0] f_target;
    int          hs_cnt;
    bit          popped;
    logic [31:0] popped_pc;
    logic [1:0]  popped_imm;

    typedef struct { logic [31:0] word; logic [1:0] exp; string name; } imm_vec_t;
    imm_vec_t tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit chance(input int p);
        return $urandom_range(99) < p;
    endfunction

    // Memory image: explicit words where loaded, otherwise a fixed hash with varied opcodes
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [6:0]  ops [8];
        logic [31:0] h;
        ops = '{7'h63, 7'h23, 7'h13, 7'h03, 7'h67, 7'h37, 7'h6F, 7'h33};
        if (memimg.exists(a)) return memimg[a];
        h = a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
        return {h[31:7], ops[h[31:29]]};
    endfunction

    function automatic logic [1:0] ref_imm(input logic [31:0] w);
        case (w[6:0])
            7'h63:               return IMM_B;
            7'h23:               return IMM_S;
            7'h13, 7'h03, 7'h67: return IMM_I;
            default:             return IMM_R;
        endcase
    endfunction

    // One cycle: check outputs at negedge, drive inputs, update the model at the posedge
    task automatic step();
        bit          rv, iv, rsp, redir, hs, pop;
        logic [31:0] tgt;
        req_t        h;
        rv = imem_req_valid;
        iv = inst_valid;
        chk("inst_valid", iv, live_buf > 0);
        chk("req_valid", rv, !fault_m && (mem_q.size() + live_buf < DEPTH));
        chk("fetch_fault", fetch_fault, fault_m);
        if (rv) chk("imem_addr", imem_addr, exp_fetch);
        if (iv) begin
            chk("inst_pc", inst_pc, exp_pop);
            chk("inst", inst, memword(exp_pop));
            chk("imm_ops", imm_ops, ref_imm(memword(exp_pop)));
        end

        imem_req_ready = chance(k_ready);
        if (f_redir && f_need_hs) imem_req_ready = 1'b1;
        rsp = (mem_q.size() > 0) && chance(k_rsp);
        if (f_redir && f_need_rsp && mem_q.size() > 0) rsp = 1'b1;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(mem_q[0].addr) : 32'h0;
        inst_ready     = chance(k_pop);
        redir = 1'b0;
        tgt   = 32'h0;
        if (f_redir && (!f_need_hs || (rv && imem_req_ready)) && (!f_need_rsp || rsp)) begin
            redir   = 1'b1;
            tgt     = f_target;
            f_redir = 1'b0;
            f_done  = 1'b1;
        end else if (!f_redir && chance(k_redir)) begin
            redir = 1'b1;
            tgt   = 32'h400 + {22'h0, 8'($urandom_range(255)), 2'b00};
        end
        redirect_valid = redir;
        redirect_pc    = tgt;
        hs  = rv && imem_req_ready;
        pop = iv && inst_ready;
        if (pop && !redir) begin
            popped     = 1'b1;
            popped_pc  = inst_pc;
            popped_imm = imm_ops;
        end

        @(posedge clk);
        if (rsp) begin
            h = mem_q.pop_front();
            if (h.ep == epoch && !redir) live_buf++;
        end
        if (hs) begin
            mem_q.push_back('{exp_fetch, epoch});
            exp_fetch = exp_fetch + 32'd4;
            hs_cnt++;
        end
        if (pop && !redir) begin
            live_buf--;
            exp_pop = exp_pop + 32'd4;
        end
        if (redir) begin
            epoch++;
            live_buf = 0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_m   = (tgt[1:0] != 2'b00);
            exp_fetch = tgt;
`else
            exp_fetch = tgt & ~32'h3;
`endif
            exp_pop = exp_fetch;
        end
        @(negedge clk);
    endtask

    task automatic wait_pop(input int maxc, output logic [31:0] pc, output logic [1:0] imm, output bit ok);
        popped = 1'b0;
        for (int i = 0; i < maxc && !popped; i++) step();
        ok  = popped;
        pc  = popped_pc;
        imm = popped_imm;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_pop: no instruction within %0d cycles", maxc);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        epoch     = 0;
        live_buf  = 0;
        exp_fetch = RESET_PC;
        exp_pop   = RESET_PC;
        fault_m   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inst_valid"}, inst_valid, 1'b0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b1);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
        chk({tag, "_fetch_fault"}, fetch_fault, 1'b0);
        chk({tag, "_imm_ops"}, imm_ops, IMM_R);
    endtask

    initial begin
        logic [31:0] pc;
        logic [1:0]  imm;
        bit          ok;

        tab[0] = '{32'h0000_0463, IMM_B, "beq"};
        tab[1] = '{32'h0011_2023, IMM_S, "sw"};
        tab[2] = '{32'h0050_0093, IMM_I, "addi"};
        tab[3] = '{32'h0000_00B7, IMM_R, "lui"};
        tab[4] = '{32'h0000_2103, IMM_I, "lw"};
        tab[5] = '{32'h0000_80E7, IMM_I, "jalr"};
        tab[6] = '{32'h0000_0117, IMM_R, "auipc"};
        tab[7] = '{32'h0080_006F, IMM_R, "jal"};
        tab[8] = '{32'h0000_0073, IMM_R, "ecall"};
        tab[9] = '{32'h0020_81B3, IMM_R, "add"};
        for (int i = 0; i < 10; i++) memimg[32'h300 + 32'(4 * i)] = tab[i].word;

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        f_redir = 1'b0; f_need_hs = 1'b0; f_need_rsp = 1'b0; f_done = 1'b0;
        f_target = 32'h0;
        hs_cnt = 0;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming with an always-ready 1-cycle memory
        k_ready = 100; k_rsp = 100; k_pop = 100; k_redir = 0;
        wait_pop(20, pc, imm, ok);
        if (ok) chk("first_pc", pc, RESET_PC);
        for (int i = 0; i < 20; i++) step();

        // Decode stalls: request count bounded by DEPTH, then release
        k_pop  = 0;
        hs_cnt = 0;
        for (int i = 0; i < 12; i++) step();
        chk("hold_req_count_le_depth", hs_cnt <= DEPTH, 1'b1);
        chk("hold_req_valid", imem_req_valid, 1'b0);
        chk("hold_inst_valid", inst_valid, 1'b1);
        k_pop = 100;
        for (int i = 0; i < 12; i++) step();

        // Redirect with two fetches in flight
        k_rsp = 0;
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
        chk("two_in_flight", mem_q.size() >= 2, 1'b1);
        f_target = 32'h100; f_need_hs = 1'b0; f_need_rsp = 1'b0; f_done = 1'b0; f_redir = 1'b1;
        step();
        k_rsp = 100;
        wait_pop(30, pc, imm, ok);
        if (ok) chk("redir_first_pc", pc, 32'h100);

        // Redirect coinciding with a request handshake and a response
        f_target = 32'h240; f_need_hs = 1'b1; f_need_rsp = 1'b1; f_done = 1'b0; f_redir = 1'b1;
        for (int i = 0; i < 30 && !f_done; i++) step();
        chk("combo_redirect_applied", f_done, 1'b1);
        f_redir = 1'b0; f_need_hs = 1'b0; f_need_rsp = 1'b0;
        wait_pop(30, pc, imm, ok);
        if (ok) chk("combo_first_pc", pc, 32'h240);

        // Immediate-format decode table
        f_target = 32'h300; f_done = 1'b0; f_redir = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            wait_pop(30, pc, imm, ok);
            if (ok) begin
                chk($sformatf("tab_pc_%s", tab[i].name), pc, 32'h300 + 32'(4 * i));
                chk($sformatf("tab_imm_%s", tab[i].name), imm, tab[i].exp);
            end
        end

        // Misaligned redirect target
        f_target = 32'h102; f_done = 1'b0; f_redir = 1'b1;
        step();
`ifdef IFETCH_MISALIGN_TRAP_EN
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) step();
        chk("trap_no_requests", hs_cnt, 0);
        chk("trap_fault", fetch_fault, 1'b1);
        chk("trap_req_valid", imem_req_valid, 1'b0);
        chk("trap_inst_valid", inst_valid, 1'b0);
        f_target = 32'h104; f_done = 1'b0; f_redir = 1'b1;
        step();
        chk("trap_cleared", fetch_fault, 1'b0);
        wait_pop(30, pc, imm, ok);
        if (ok) chk("trap_resume_pc", pc, 32'h104);
`else
        chk("noTrap_fault", fetch_fault, 1'b0);
        wait_pop(30, pc, imm, ok);
        if (ok) chk("noTrap_aligned_pc", pc, 32'h100);
`endif

        // Randomized traffic against the model
        k_ready = 70; k_rsp = 60; k_pop = 60; k_redir = 3;
        for (int i = 0; i < 3000; i++) step();

        // Reset in the middle of traffic
        k_redir = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k_ready = 100; k_rsp = 100; k_pop = 100;
        wait_pop(20, pc, imm, ok);
        if (ok) chk("midreset_first_pc", pc, RESET_PC);
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
